vdot_host_seq: RTL and testbench
================================

# vdot_host_seq

Host-side sequencer that drives the 4-bit-word vector dot-product accelerator through its command pins. It accepts a job (length plus a stream of A then B operand words), resets the accelerator, clears its result words, loads length and operands with WRITE commands, issues RUN, polls the state pins until DONE, reads both result nibbles and returns the 8-bit result on a valid/ready port. It sits between the system-side operand source and the accelerator's `ui_in`/`uio_in`/`uio_out` pins.

## Interface
- `MAX_LEN`, 16: vector capacity in words; `len`=0 encodes `MAX_LEN`.
- `TIMEOUT`, 255: max cycles in WAIT before abort; counter width `$clog2(TIMEOUT+1)`.
- `clk` in 1: clock. One clock; reset is synchronous and active-low, `rst_n`.
- `rst_n` in 1: synchronous active-low reset.
- `start` in 1: job request, sampled only in IDLE.
- `len` in 4: vector length, latched with `start`.
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in 4: operand stream, A[0..N-1] then B[0..N-1].
- `res_valid` out 1 / `res_ready` in 1 / `res_data` out 8: result {hi,lo}.
- `busy` out 1: high whenever FSM not IDLE.
- `timeout_err` out 1: sticky; cleared by next accepted `start`.
- `acc_cmd` out 8: to accelerator `ui_in`; [7:6] op (0 READ, 1 WRITE, 2 RUN), [5:0] address.
- `acc_wdata` out 4: to accelerator `uio_in[3:0]`.
- `acc_rdata` in 4: from accelerator `uio_out[3:0]`.
- `acc_state` in 2: from accelerator `uio_out[5:4]` (0 RESET, 1 RUNNING, 3 ACCUMULATING, 2 DONE).
- `acc_rst_n` out 1: accelerator reset.

## Operation
- Address map: 0 length; A[k] at 1+k; B[k] at 17+k; result lo 33, hi 34.
- All `acc_*` outputs, `in_ready`, `res_*` registered. Idle pin value: `acc_cmd`=8'h00 (READ 0), `acc_wdata`=0, `acc_rst_n`=1.
- States: IDLE -> ARST -> WLEN -> LOAD -> CLR0 -> CLR1 -> RUN -> WAIT -> RDLO -> RDHI -> OUT -> IDLE.
- IDLE: `start`=1 latches `len` (N = len==0 ? 16 : len), clears `timeout_err`, goes ARST.
- ARST: `acc_rst_n`=0 one cycle, cmd READ 0.
- WLEN: cmd {WRITE,0}, wdata=`len` (raw 4-bit value, 0 kept as 0).
- LOAD: `in_ready`=1; each accepted word k (0..2N-1) presents {WRITE, k<N ? 1+k : 17+k-N} with wdata=word next cycle; cycles without acceptance present READ 0. After word 2N-1 accepted, go CLR0.
- CLR0/CLR1: WRITE 33 data 0, then WRITE 34 data 0 (accelerator result accumulates onto prior contents).
- RUN: cmd {RUN,0} exactly one cycle.
- WAIT: cmd READ 0; leave when `acc_state`==2'b10. Counter increments per WAIT cycle; reaching `TIMEOUT` without DONE sets `timeout_err`, returns IDLE, no result.
- RDLO/RDHI: cmd READ 33 / READ 34; `acc_rdata` captured at end of that same cycle.
- OUT: `res_valid`=1, `res_data`={hi,lo} held stable until `res_ready`; handshake cycle returns IDLE.
- Result is accelerator's sum modulo 256; sequencer does no arithmetic.
- `start` while busy ignored; `in_valid` outside LOAD ignored (`in_ready`=0).

## Timing
- Reset: FSM IDLE, `busy`=0, `in_ready`=0, `res_valid`=0, `res_data`=0, `timeout_err`=0, `acc_cmd`=0, `acc_wdata`=0; `acc_rst_n`=0 while `rst_n`=0, 1 the cycle after release.
- Reset mid-job: abandon at next edge, no result, accelerator reset with it.
- `start` at edge 0: ARST cycle 1, WLEN cycle 2, first LOAD cycle 3.
- Unstalled stream: 2N words in 2N cycles; best-case `start` to `res_valid` = 2N+9+W cycles, W = WAIT cycles (accelerator nominal W=3).
- `res_valid` and `res_ready` same cycle: transfer, IDLE next cycle; new `start` accepted the cycle after.

## Test plan
- len=3, A={1,2,3}, B={4,5,6}, no stalls -> pin sequence WRITE0/3, WRITE1..3, WRITE17..19, WRITE33/0, WRITE34/0, RUN; `res_data`=8'h20.
- len=0, all 32 words 4'hF -> 16 A writes at 1..16, B at 17..32; `res_data`=8'h10 (3600 mod 256).
- len=2, `in_valid` toggled every other cycle, `res_ready` low 5 cycles -> only accepted words written, `res_data` stable through stall, =A·B.
- Model holds `acc_state`=01 -> `timeout_err`=1 after TIMEOUT WAIT cycles, no `res_valid`, next `start` clears it.
- `rst_n` low during LOAD then new job len=1 A=7 B=9 -> `acc_rst_n` low during reset, `res_data`=8'h3F.
- Back-to-back jobs (2 then 1) -> second result excludes first sum (clears verified).

Source files
------------

// File: rtl/vdot_host_seq.sv
// vdot_host_seq: host-side sequencer that loads, runs and reads back the nibble dot-product accelerator.
// Latency: start to res_valid = 2N+9+W cycles unstalled (N words per vector, W accelerator wait cycles).
// Backpressure: operands accepted via in_valid/in_ready in LOAD only; result held on res_valid until res_ready.
module vdot_host_seq #(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] len,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] acc_cmd,
    output logic [3:0] acc_wdata,
    input  logic [3:0] acc_rdata,
    input  logic [1:0] acc_state,
    output logic       acc_rst_n
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // Accelerator register map: length, A vector, B vector, result nibbles.
    localparam logic [5:0] ADDR_LEN = 6'd0;
    localparam logic [5:0] ADDR_A   = 6'(1);
    localparam logic [5:0] ADDR_B   = 6'(1 + MAX_LEN);
    localparam logic [5:0] ADDR_LO  = 6'(1 + 2 * MAX_LEN);
    localparam logic [5:0] ADDR_HI  = 6'(2 + 2 * MAX_LEN);

    // The state register is aligned with the pins: the registered outputs
    // in a given cycle are the ones belonging to the current state.
    typedef enum logic [3:0] {
        S_IDLE,
        S_ARST,
        S_WLEN,
        S_LOAD,
        S_CLR0,
        S_CLR1,
        S_RUN,
        S_WAIT,
        S_RDLO,
        S_RDHI,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [3:0]    len_q, len_nxt;
    logic [5:0]    n_q, n_nxt;          // effective vector length (1..MAX_LEN)
    logic [5:0]    k_q, k_nxt;          // operand words accepted so far
    logic [TW-1:0] wcnt_q, wcnt_nxt;    // WAIT cycles spent
    logic [3:0]    lo_q, lo_nxt;        // low result nibble captured in RDLO

    logic          in_ready_nxt;
    logic          res_valid_nxt;
    logic [7:0]    res_data_nxt;
    logic          terr_nxt;
    logic [7:0]    cmd_nxt;
    logic [3:0]    wdata_nxt;
    logic          arst_n_nxt;

    assign busy = (state != S_IDLE);

    // State register; a synchronous reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus next values of every registered pin and datapath register.
    always_comb begin
        state_nxt     = state;
        len_nxt       = len_q;
        n_nxt         = n_q;
        k_nxt         = k_q;
        wcnt_nxt      = wcnt_q;
        lo_nxt        = lo_q;
        in_ready_nxt  = 1'b0;
        res_valid_nxt = 1'b0;
        res_data_nxt  = res_data;
        terr_nxt      = timeout_err;
        cmd_nxt       = {OP_READ, 6'd0};
        wdata_nxt     = 4'd0;
        arst_n_nxt    = 1'b1;

        case (state)
            S_IDLE: begin
                if (start) begin
                    len_nxt    = len;
                    n_nxt      = (len == 4'd0) ? 6'(MAX_LEN) : {2'b00, len};
                    k_nxt      = 6'd0;
                    terr_nxt   = 1'b0;
                    arst_n_nxt = 1'b0;
                    state_nxt  = S_ARST;
                end
            end
            S_ARST: begin
                // Raw length is written; the accelerator itself maps 0 to a full vector.
                cmd_nxt   = {OP_WRITE, ADDR_LEN};
                wdata_nxt = len_q;
                state_nxt = S_WLEN;
            end
            S_WLEN: begin
                in_ready_nxt = 1'b1;
                state_nxt    = S_LOAD;
            end
            S_LOAD: begin
                if (in_ready) begin
                    in_ready_nxt = 1'b1;
                    if (in_valid) begin
                        cmd_nxt   = {OP_WRITE, (k_q < n_q) ? (ADDR_A + k_q) : (ADDR_B + k_q - n_q)};
                        wdata_nxt = in_data;
                        k_nxt     = k_q + 6'd1;
                        if (k_q == ((n_q << 1) - 6'd1)) begin
                            in_ready_nxt = 1'b0;
                        end
                    end
                end else begin
                    // Drain cycle: the last operand write is on the pins now.
                    cmd_nxt   = {OP_WRITE, ADDR_LO};
                    state_nxt = S_CLR0;
                end
            end
            S_CLR0: begin
                // Result accumulates onto prior contents, so both nibbles are zeroed.
                cmd_nxt   = {OP_WRITE, ADDR_HI};
                state_nxt = S_CLR1;
            end
            S_CLR1: begin
                cmd_nxt   = {OP_RUN, 6'd0};
                state_nxt = S_RUN;
            end
            S_RUN: begin
                wcnt_nxt  = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (acc_state == ST_DONE) begin
                    cmd_nxt   = {OP_READ, ADDR_LO};
                    state_nxt = S_RDLO;
                end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                    terr_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    wcnt_nxt = wcnt_q + TW'(1);
                end
            end
            S_RDLO: begin
                lo_nxt    = acc_rdata;
                cmd_nxt   = {OP_READ, ADDR_HI};
                state_nxt = S_RDHI;
            end
            S_RDHI: begin
                res_data_nxt  = {acc_rdata, lo_q};
                res_valid_nxt = 1'b1;
                state_nxt     = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end else begin
                    res_valid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output pins and datapath registers; accelerator reset follows our reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q       <= 4'd0;
            n_q         <= 6'd0;
            k_q         <= 6'd0;
            wcnt_q      <= '0;
            lo_q        <= 4'd0;
            in_ready    <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= 8'd0;
            timeout_err <= 1'b0;
            acc_cmd     <= 8'd0;
            acc_wdata   <= 4'd0;
            acc_rst_n   <= 1'b0;
        end else begin
            len_q       <= len_nxt;
            n_q         <= n_nxt;
            k_q         <= k_nxt;
            wcnt_q      <= wcnt_nxt;
            lo_q        <= lo_nxt;
            in_ready    <= in_ready_nxt;
            res_valid   <= res_valid_nxt;
            res_data    <= res_data_nxt;
            timeout_err <= terr_nxt;
            acc_cmd     <= cmd_nxt;
            acc_wdata   <= wdata_nxt;
            acc_rst_n   <= arst_n_nxt;
        end
    end

endmodule

// File: tb/tb_vdot_host_seq.sv
// tb_vdot_host_seq: drives jobs into vdot_host_seq against a behavioural accelerator.
// Expected pin writes and results are queued when a job is issued and checked as they appear.
// Covers reset values, latency, stalls on both ports, timeout, mid-job reset and result clearing.
module tb_vdot_host_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] len = 4'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       busy;
    logic       timeout_err;
    logic [7:0] acc_cmd;
    logic [3:0] acc_wdata;
    logic [3:0] acc_rdata;
    logic [1:0] acc_state;
    logic       acc_rst_n;

    always #5 clk = ~clk;

    vdot_host_seq #(.MAX_LEN(16), .TIMEOUT(255)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .timeout_err(timeout_err),
        .acc_cmd    (acc_cmd),
        .acc_wdata  (acc_wdata),
        .acc_rdata  (acc_rdata),
        .acc_state  (acc_state),
        .acc_rst_n  (acc_rst_n)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int exp_wr[$];   // addr*16 + data for every expected WRITE command, in order
    int exp_res[$];  // expected 8-bit results

    logic [3:0] va [16];
    logic [3:0] vb [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural accelerator: register file, RUN takes three WAIT-visible cycles, result accumulates.
    logic [3:0] mem [0:63] = '{default: 4'h0};
    logic [1:0] st = 2'd0;
    int         rcnt = 0;
    bit         hang = 1'b0;

    assign acc_state = st;
    assign acc_rdata = mem[acc_cmd[5:0]];

    function automatic logic [7:0] dot8();
        int n;
        int s;
        n = (mem[0] == 4'd0) ? 16 : int'(mem[0]);
        s = 0;
        for (int k = 0; k < n; k++) s += int'(mem[1 + k]) * int'(mem[17 + k]);
        return 8'(s);
    endfunction

    always @(posedge clk) begin
        if (acc_rst_n === 1'b0) begin
            st   <= 2'd0;
            rcnt <= 0;
        end else if (acc_cmd[7:6] == 2'd1) begin
            mem[acc_cmd[5:0]] <= acc_wdata;
        end else if (acc_cmd[7:6] == 2'd2) begin
            st   <= 2'd1;
            rcnt <= 2;
        end else if ((st == 2'd1 || st == 2'd3) && !hang) begin
            if (rcnt <= 1) begin
                st <= 2'd2;
                {mem[34], mem[33]} <= {mem[34], mem[33]} + dot8();
            end else begin
                rcnt <= rcnt - 1;
                st   <= 2'd3;
            end
        end
    end

    // Scoreboard side: compare pin writes and result transfers away from the active edge.
    always @(negedge clk) begin
        if (acc_cmd[7:6] == 2'd1) begin
            if (exp_wr.size() == 0) chk("wr_extra", 32'({acc_cmd[5:0], acc_wdata}), 32'hFFFF);
            else chk("wr", 32'({acc_cmd[5:0], acc_wdata}), exp_wr.pop_front());
        end
        if (res_valid === 1'b1) begin
            if (exp_res.size() == 0) chk("res_extra", 32'(res_data), 32'hFFFF);
            else if (res_ready) chk("res", 32'(res_data), exp_res.pop_front());
            else chk("res_hold", 32'(res_data), exp_res[0]);
        end
    end

    task automatic run_job(input int ln, input bit tog, input int rstall, input int abort_at, input bit hng);
        int n;
        int nw;
        int idx;
        int t0;
        int s;
        bit ph;
        bit acc;
        bit seen;
        n  = (ln == 0) ? 16 : ln;
        nw = (abort_at >= 0) ? abort_at : 2 * n;
        for (int i = 0; i < 50 && busy; i++) begin
            @(posedge clk); #1;
        end
        chk("idle_before", 32'(busy), 0);
        hang = hng;
        exp_wr.push_back(ln);
        for (int k = 0; k < nw; k++) begin
            if (k < n) exp_wr.push_back((1 + k) * 16 + int'(va[k]));
            else exp_wr.push_back((17 + k - n) * 16 + int'(vb[k - n]));
        end
        if (abort_at < 0) begin
            exp_wr.push_back(33 * 16);
            exp_wr.push_back(34 * 16);
            if (!hng) begin
                s = 0;
                for (int k = 0; k < n; k++) s += int'(va[k]) * int'(vb[k]);
                exp_res.push_back(s % 256);
            end
        end
        res_ready = (rstall == 0);
        len   = 4'(ln);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        chk("busy", 32'(busy), 1);
        chk("terr_clr", 32'(timeout_err), 0);
        chk("arst_pulse", 32'(acc_rst_n), 0);
        idx = 0;
        ph  = 1'b1;
        for (int c = 0; c < 200 && idx < nw; c++) begin
            in_valid = tog ? ph : 1'b1;
            ph = ~ph;
            if (in_valid) in_data = (idx < n) ? va[idx] : vb[idx - n];
            else in_data = 4'hA;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("stream", idx, nw);
        if (abort_at >= 0) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            chk("mid_rst_acc", 32'(acc_rst_n), 0);
            chk("mid_rst_busy", 32'(busy), 0);
            chk("mid_rst_rdy", 32'(in_ready), 0);
            chk("mid_rst_vld", 32'(res_valid), 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            chk("rel_acc_rst", 32'(acc_rst_n), 1);
        end else begin
            seen = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if (hng) begin
                    if (res_valid) chk("no_res", 32'(res_valid), 0);
                    if (!busy) begin
                        seen = 1'b1;
                        break;
                    end
                end else if (res_valid) begin
                    seen = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            chk("done_seen", 32'(seen), 1);
            if (hng) begin
                chk("to_lat", cyc - t0 + 1, 2 * n + 262);
                chk("terr_set", 32'(timeout_err), 1);
                chk("rdy_idle", 32'(in_ready), 0);
            end else begin
                if (!tog) chk("lat", cyc - t0 + 1, 2 * n + 12);
                for (int c = 0; c < rstall; c++) begin
                    @(posedge clk); #1;
                    chk("hold_vld", 32'(res_valid), 1);
                end
                res_ready = 1'b1;
                @(posedge clk); #1;
                res_ready = 1'b0;
                chk("vld_drop", 32'(res_valid), 0);
                chk("idle_after", 32'(busy), 0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        chk("rst_cmd", 32'(acc_cmd), 0);
        chk("rst_wdata", 32'(acc_wdata), 0);
        chk("rst_acc_rst", 32'(acc_rst_n), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_acc_rst", 32'(acc_rst_n), 1);

        // len=3, unstalled: 1*4+2*5+3*6 = 0x20
        va[0] = 4'd1; va[1] = 4'd2; va[2] = 4'd3;
        vb[0] = 4'd4; vb[1] = 4'd5; vb[2] = 4'd6;
        run_job(3, 1'b0, 0, -1, 1'b0);

        // len=0 means 16 words of 4'hF each: 3600 mod 256 = 0x10
        for (int k = 0; k < 16; k++) begin
            va[k] = 4'hF;
            vb[k] = 4'hF;
        end
        run_job(0, 1'b0, 0, -1, 1'b0);

        // len=2 with gappy operand stream and result backpressure
        va[0] = 4'd3; va[1] = 4'd7;
        vb[0] = 4'd5; vb[1] = 4'd2;
        run_job(2, 1'b1, 5, -1, 1'b0);

        // accelerator never finishes: timeout, no result
        va[0] = 4'd2; vb[0] = 4'd3;
        run_job(1, 1'b0, 0, -1, 1'b1);

        // reset during LOAD after two words
        va[0] = 4'd1; va[1] = 4'd2; va[2] = 4'd3; va[3] = 4'd4;
        vb[0] = 4'd5; vb[1] = 4'd6; vb[2] = 4'd7; vb[3] = 4'd8;
        run_job(4, 1'b0, 0, 2, 1'b0);

        // fresh job after reset: 7*9 = 0x3F
        va[0] = 4'd7; vb[0] = 4'd9;
        run_job(1, 1'b0, 0, -1, 1'b0);

        // back-to-back jobs: second result must not include the first
        va[0] = 4'd9; va[1] = 4'd8;
        vb[0] = 4'd7; vb[1] = 4'd6;
        run_job(2, 1'b0, 0, -1, 1'b0);
        va[0] = 4'd5; vb[0] = 4'd5;
        run_job(1, 1'b0, 0, -1, 1'b0);

        // random length and data with stalls on both sides
        begin
            int rl;
            rl = int'($urandom_range(15, 1));
            for (int k = 0; k < 16; k++) begin
                va[k] = 4'($urandom_range(15, 0));
                vb[k] = 4'($urandom_range(15, 0));
            end
            run_job(rl, 1'b1, 2, -1, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("wr_left", exp_wr.size(), 0);
        chk("res_left", exp_res.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
